// File: rtl/rv32_imm_encoder_pkg.sv
// -----------------------------------------------------------------------------
// rv32_imm_encoder_pkg
// Shared constants and helpers for the RV32 immediate encoder:
//   - base opcodes that select the immediate format
//   - ADDI funct3 and the encoder FSM state encodings
//   - immediate format enumeration and opcode -> format decode
//   - helpers building the LUI / ADDI base words used by the `li` expansion
// -----------------------------------------------------------------------------
package rv32_imm_encoder_pkg;

    localparam logic [6:0] OPCODE_ARITH_I = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;

    localparam logic [2:0] FUNCT3_ADDI    = 3'b000;

    // ST_SECOND: the LUI half of a two-word `li` is on the output and the
    // ADDI half waits in the pending register.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_U = 3'd2,
        FMT_J = 3'd3,
        FMT_B = 3'd4
    } fmt_t;

    // Unknown opcodes deliberately fall back to the I format.
    function automatic fmt_t opcode_fmt(input logic [6:0] opcode);
        fmt_t fmt;
        case (opcode)
            OPCODE_STORE:              fmt = FMT_S;
            OPCODE_LUI, OPCODE_AUIPC:  fmt = FMT_U;
            OPCODE_JAL:                fmt = FMT_J;
            OPCODE_BRANCH:             fmt = FMT_B;
            default:                   fmt = FMT_I;
        endcase
        return fmt;
    endfunction

    // ADDI rd, rs1, 0 with the immediate field left empty for the packer.
    function automatic logic [31:0] make_addi(input logic [4:0] rd,
                                              input logic [4:0] rs1);
        return {12'b0, rs1, FUNCT3_ADDI, rd, OPCODE_ARITH_I};
    endfunction

    // LUI rd, 0 with the immediate field left empty for the packer.
    function automatic logic [31:0] make_lui(input logic [4:0] rd);
        return {20'b0, rd, OPCODE_LUI};
    endfunction

endpackage

// File: rtl/rv32_imm_pack.sv
// -----------------------------------------------------------------------------
// rv32_imm_pack
// Combinational immediate insertion: scatters the bits of imm into the
// positions the base word's opcode dictates (I/S/U/J/B) and ORs them into base.
//
// Ports:
//   base  in  32  instruction with immediate fields zero
//   imm   in  32  immediate, two's complement
//   ir    out 32  base with immediate bits inserted
//   err   out 1   immediate does not fit the selected format
//
// Optional feature macro: RV32_IMM_RANGE_CHECK_EN
//   defined   -> err reports range/alignment violations (encoding still truncates)
//   undefined -> err is tied to 0 and no check logic exists
// -----------------------------------------------------------------------------
module rv32_imm_pack
    import rv32_imm_encoder_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    output logic [31:0] ir,
    output logic        err
);

    fmt_t        fmt;
    logic [31:0] field;

    always_comb begin
        fmt   = opcode_fmt(base[6:0]);
        field = '0;
        case (fmt)
            FMT_S:   field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            FMT_U:   field = {imm[31:12], 12'b0};
            FMT_J:   field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            FMT_B:   field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            default: field = {imm[11:0], 20'b0};
        endcase
        ir = base | field;
    end

`ifdef RV32_IMM_RANGE_CHECK_EN
    // A value fits an N-bit signed field when every bit above the field's
    // sign bit equals that sign bit.
    always_comb begin
        case (fmt)
            FMT_U:   err = |imm[11:0];
            FMT_J:   err = (imm[31:20] != {12{imm[20]}}) || imm[0];
            FMT_B:   err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            default: err = (imm[31:11] != {21{imm[11]}});
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/rv32_imm_encoder.sv
// -----------------------------------------------------------------------------
// rv32_imm_encoder
// Packs a 32-bit immediate into a base RV32 instruction word, or expands
// `li rd, imm` into ADDI / LUI / LUI+ADDI, behind a registered valid/ready
// output stage.
//
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   asynchronous active-high reset
//   in_valid   in  1   request present
//   in_ready   out 1   request accepted on in_valid && in_ready
//   in_base    in  32  base instruction (only [11:7] = rd used for li)
//   in_imm     in  32  immediate, two's complement
//   in_li      in  1   expand as `li rd, in_imm`
//   out_valid  out 1   out_ir holds a valid instruction
//   out_ready  in  1   consumer takes out_ir on out_valid && out_ready
//   out_ir     out 32  encoded instruction
//   out_err    out 1   immediate not representable (qualified by out_valid)
//
// Optional feature macro: RV32_IMM_RANGE_CHECK_EN (range checking in the packer;
// without it out_err stays 0).
// -----------------------------------------------------------------------------
module rv32_imm_encoder
    import rv32_imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    input  logic        in_li,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic        out_err
);

    // Packer slot 0 builds the first (or only) word, slot 1 the pending ADDI.
    localparam int N_PACK = 2;

    state_t      state_reg, state_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_ir_reg, out_ir_next;
    logic        out_err_reg, out_err_next;
    logic [31:0] pend_ir_reg, pend_ir_next;
    logic        pend_err_reg, pend_err_next;

    logic [4:0]  li_rd;
    logic [19:0] li_hi;
    logic        li_small;
    logic        li_two;
    logic        accept;
    logic        consume;

    logic [31:0] pack_base [N_PACK];
    logic [31:0] pack_imm  [N_PACK];
    logic [31:0] pack_ir   [N_PACK];
    logic        pack_err  [N_PACK];

    // ---------------------------------------------------------------------
    // li expansion decode
    // ---------------------------------------------------------------------
    assign li_rd    = in_base[11:7];
    // (imm + 0x800) >> 12: adding 0x800 only carries into bit 12 when
    // bit 11 is set, so the rounded upper part is imm[31:12] + imm[11].
    // This compensates for ADDI sign-extending its 12-bit immediate.
    assign li_hi    = in_imm[31:12] + {19'b0, in_imm[11]};
    assign li_small = (in_imm[31:11] == {21{in_imm[11]}});
    assign li_two   = !li_small && (in_imm[11:0] != 12'd0);

    always_comb begin
        pack_base[0] = in_base;
        pack_imm[0]  = in_imm;
        if (in_li) begin
            if (li_small) begin
                pack_base[0] = make_addi(li_rd, 5'd0);
            end else begin
                pack_base[0] = make_lui(li_rd);
                pack_imm[0]  = {li_hi, 12'b0};
            end
        end
        // Second half of a two-word li: ADDI rd, rd, lo. Sign-extending lo
        // keeps the range checker quiet for this always-legal word.
        pack_base[1] = make_addi(li_rd, li_rd);
        pack_imm[1]  = {{20{in_imm[11]}}, in_imm[11:0]};
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_PACK; gi++) begin : g_pack
            rv32_imm_pack u_pack (
                .base (pack_base[gi]),
                .imm  (pack_imm[gi]),
                .ir   (pack_ir[gi]),
                .err  (pack_err[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Control FSM and output stage (next-state logic)
    // ---------------------------------------------------------------------
    assign consume = out_valid_reg && out_ready;
    assign accept  = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_ir_next    = out_ir_reg;
        out_err_next   = out_err_reg;
        pend_ir_next   = pend_ir_reg;
        pend_err_next  = pend_err_reg;
        in_ready       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Output slot is free, or is being emptied this very edge.
                in_ready = !out_valid_reg || out_ready;
                if (accept) begin
                    out_valid_next = 1'b1;
                    out_ir_next    = pack_ir[0];
                    out_err_next   = pack_err[0] && !in_li;
                    if (in_li && li_two) begin
                        pend_ir_next  = pack_ir[1];
                        pend_err_next = 1'b0;
                        state_next    = ST_SECOND;
                    end
                end else if (consume) begin
                    out_valid_next = 1'b0;
                end
            end

            ST_SECOND: begin
                in_ready = 1'b0;
                if (consume) begin
                    out_valid_next = 1'b1;
                    out_ir_next    = pend_ir_reg;
                    out_err_next   = pend_err_reg;
                    pend_ir_next   = '0;
                    pend_err_next  = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            out_ir_reg    <= '0;
            out_err_reg   <= 1'b0;
            pend_ir_reg   <= '0;
            pend_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_ir_reg    <= out_ir_next;
            out_err_reg   <= out_err_next;
            pend_ir_reg   <= pend_ir_next;
            pend_err_reg  <= pend_err_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_ir    = out_ir_reg;
    assign out_err   = out_err_reg;

endmodule

// File: tb/tb_rv32_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_rv32_imm_encoder
// Self-checking bench for rv32_imm_encoder: directed vector table, hand-written
// backpressure / li / reset sequences, and randomized traffic compared against
// a bit-mapping reference model. Expected words are queued in order and
// compared as the consumer takes them.
// -----------------------------------------------------------------------------
module tb_rv32_imm_encoder;

`ifdef RV32_IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic        in_li;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic        out_err;

    always #5 clk = ~clk;

    rv32_imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .in_li     (in_li),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_err   (out_err)
    );

    typedef struct {
        logic [31:0] ir;
        logic        err;
    } word_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] imm;
        logic        li;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        e0;
    } vec_t;

    word_t exp_q[$];
    vec_t  vecs[15];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_words  = 0;
    bit    rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, required %08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // 0=I 1=S 2=U 3=J 4=B
    function automatic int fmt_of(input logic [6:0] op);
        case (op)
            7'h23:        return 1;
            7'h37, 7'h17: return 2;
            7'h6F:        return 3;
            7'h63:        return 4;
            default:      return 0;
        endcase
    endfunction

    // Which immediate bit lands on instruction bit b (-1: none).
    function automatic int imm_src(input int f, input int b);
        case (f)
            1: begin
                if (b >= 25) return b - 20;
                if (b >= 7 && b <= 11) return b - 7;
                return -1;
            end
            2: return (b >= 12) ? b : -1;
            3: begin
                if (b == 31) return 20;
                if (b >= 21) return b - 20;
                if (b == 20) return 11;
                if (b >= 12) return b;
                return -1;
            end
            4: begin
                if (b == 31) return 12;
                if (b >= 25) return b - 20;
                if (b >= 8 && b <= 11) return b - 7;
                if (b == 7) return 11;
                return -1;
            end
            default: return (b >= 20) ? b - 20 : -1;
        endcase
    endfunction

    function automatic logic [31:0] model_pack(input logic [31:0] base, input logic [31:0] imm);
        logic [31:0] ir = base;
        int f = fmt_of(base[6:0]);
        for (int b = 0; b < 32; b++) begin
            int s = imm_src(f, b);
            if (s >= 0 && imm[s]) ir[b] = 1'b1;
        end
        return ir;
    endfunction

    function automatic logic model_err(input logic [31:0] base, input logic [31:0] imm);
        int signed v = imm;
        if (!RC) return 1'b0;
        case (fmt_of(base[6:0]))
            2:       return (imm % 4096) != 0;
            3:       return !(v >= -1048576 && v <= 1048575) || (v % 2 != 0);
            4:       return !(v >= -4096 && v <= 4095) || (v % 2 != 0);
            default: return !(v >= -2048 && v <= 2047);
        endcase
    endfunction

    task automatic model_push(input logic [31:0] base, input logic [31:0] imm, input logic li);
        word_t w;
        int signed v = imm;
        logic [31:0] rd, lo, hi;
        if (!li) begin
            w.ir = model_pack(base, imm);
            w.err = model_err(base, imm);
            exp_q.push_back(w);
            return;
        end
        rd = {27'b0, base[11:7]};
        lo = imm & 32'hFFF;
        hi = (imm + 32'h800) >> 12;
        w.err = 1'b0;
        if (v >= -2048 && v <= 2047) begin
            w.ir = (lo << 20) | (rd << 7) | 32'h13;
            exp_q.push_back(w);
        end else begin
            w.ir = (hi << 12) | (rd << 7) | 32'h37;
            exp_q.push_back(w);
            if (lo != 0) begin
                w.ir = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
                exp_q.push_back(w);
            end
        end
    endtask

    // ---------------- driver / monitor ----------------
    task automatic send(input logic [31:0] b, input logic [31:0] i, input logic l, output int waits);
        bit done = 1'b0;
        bit timeout = 1'b0;
        in_base = b; in_imm = i; in_li = l; in_valid = 1'b1;
        waits = 0;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    n_checks++;
                    $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required accept", waits);
                    done = 1'b1;
                    timeout = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!timeout) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic mon_loop();
        word_t w;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_words++;
                $display("word %0d: ir=%08h err=%0b", n_words, out_ir, out_err);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %08h, required no word", out_ir);
                end else begin
                    w = exp_q.pop_front();
                    check("out_ir", out_ir, w.ir);
                    check("out_err", {31'b0, out_err}, {31'b0, w.err});
                end
            end
        end
    endtask

    task automatic drain();
        int cnt = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && cnt < 300) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int waits;
        word_t w;
        logic [31:0] b, i;
        logic l;
        logic [6:0] ops [8];

        vecs[0]  = '{32'h00000093, 32'hFFFFFFFF, 1'b0, 1, 32'hFFF00093, 32'h0, 1'b0};
        vecs[1]  = '{32'h00208063, 32'h00000008, 1'b0, 1, 32'h00208463, 32'h0, 1'b0};
        vecs[2]  = '{32'h00208063, 32'h00000007, 1'b0, 1, 32'h00208363, 32'h0, RC};
        vecs[3]  = '{32'h00000280, 32'h12345678, 1'b1, 2, 32'h123452B7, 32'h67828293, 1'b0};
        vecs[4]  = '{32'h00000280, 32'h00000FFF, 1'b1, 2, 32'h000012B7, 32'hFFF28293, 1'b0};
        vecs[5]  = '{32'h00000280, 32'h00010000, 1'b1, 1, 32'h000102B7, 32'h0, 1'b0};
        vecs[6]  = '{32'h0020A023, 32'h000007FC, 1'b0, 1, 32'h7E20AE23, 32'h0, 1'b0};
        vecs[7]  = '{32'h000002B7, 32'hABCDE123, 1'b0, 1, 32'hABCDE2B7, 32'h0, RC};
        vecs[8]  = '{32'h000000EF, 32'h00000800, 1'b0, 1, 32'h001000EF, 32'h0, 1'b0};
        vecs[9]  = '{32'h000000EF, 32'hFFFFFFFE, 1'b0, 1, 32'hFFFFF0EF, 32'h0, 1'b0};
        vecs[10] = '{32'h00000080, 32'hFFFFF800, 1'b1, 1, 32'h80000093, 32'h0, 1'b0};
        vecs[11] = '{32'h00000080, 32'h00000800, 1'b1, 2, 32'h000010B7, 32'h80008093, 1'b0};
        vecs[12] = '{32'h0000007F, 32'h00000123, 1'b0, 1, 32'h1230007F, 32'h0, 1'b0};
        vecs[13] = '{32'h00000093, 32'h00000800, 1'b0, 1, 32'h80000093, 32'h0, RC};
        vecs[14] = '{32'h00208063, 32'hFFFFFFFC, 1'b0, 1, 32'hFE208EE3, 32'h0, 1'b0};

        ops = '{7'h13, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h0B};

        rst = 1'b1; in_valid = 1'b0; in_base = '0; in_imm = '0; in_li = 1'b0; out_ready = 1'b0;
        fork
            mon_loop();
        join_none

        // Reset state, while asserted and after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_ir", out_ir, 32'd0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Directed vectors, continuous out_ready.
        out_ready = 1'b1;
        for (int v = 0; v < 15; v++) begin
            w.ir = vecs[v].w0; w.err = vecs[v].e0;
            exp_q.push_back(w);
            if (vecs[v].n == 2) begin
                w.ir = vecs[v].w1; w.err = 1'b0;
                exp_q.push_back(w);
            end
            send(vecs[v].base, vecs[v].imm, vecs[v].li, waits);
            if (vecs[v].n == 2) begin
                @(negedge clk);
                check("li_second_in_ready", {31'b0, in_ready}, 32'd0);
            end
        end
        drain();

        // Backpressure: held word stays stable, then back-to-back accepts.
        out_ready = 1'b0;
        model_push(32'h00000093, 32'h0000002A, 1'b0);
        send(32'h00000093, 32'h0000002A, 1'b0, waits);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_out_ir", out_ir, 32'h02A00093);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            model_push(32'h00000113, 32'(k + 1), 1'b0);
            send(32'h00000113, 32'(k + 1), 1'b0, waits);
            check("b2b_no_wait", waits, 0);
        end
        drain();

        // Reset asserted while the ADDI half is pending.
        out_ready = 1'b0;
        send(32'h00000280, 32'h12345678, 1'b1, waits);
        @(negedge clk);
        check("mid_li_lui_word", out_ir, 32'h123452B7);
        check("mid_li_in_ready", {31'b0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_out_ir", out_ir, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_addi_after_rst", {31'b0, out_valid}, 32'd0);
        end
        check("idle_in_ready_after_rst", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        rand_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            b = $urandom;
            b[6:0] = ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 4))
                0:       i = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       i = $urandom;
                2:       i = $urandom & 32'hFFFFF000;
                3:       i = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
                default: i = 32'hFFFFF800 + 32'($urandom_range(0, 4095));
            endcase
            l = ($urandom_range(0, 2) == 0);
            model_push(b, i, l);
            send(b, i, l, waits);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        rand_ready = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32_imm_encoder.md
# rv32_imm_encoder

Inverse of the pipeline's immediate generator: takes a base instruction word with all immediate fields zero plus a 32-bit immediate, and packs the immediate into the bit positions dictated by the base word's opcode (I, S, U, J, B formats). It also expands the `li rd, imm` pseudo-instruction into one or two real instructions (LUI and/or ADDI). It sits between the boot/test-program sequencer and instruction memory, with a registered valid/ready output stage.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge.
- in_base  in  32  instruction with opcode, rd, rs1, rs2, funct3 and funct7 placed and immediate bits zero. When in_li=1, only in_base[11:7] (rd) is used.
- in_imm  in  32  immediate, two's complement.
- in_li  in  1  1 = expand as `li rd, in_imm`.
- out_valid  out  1  out_ir holds a valid instruction.
- out_ready  in  1  consumer takes out_ir when out_valid && out_ready.
- out_ir  out  32  encoded instruction.
- out_err  out  1  immediate not representable in the selected format; qualified by out_valid.

## Operation
- Format is selected by in_base[6:0]:
  - Arith_I, JALR, and any unknown opcode: I format. IR[31:20] = imm[11:0].
  - Store: S format. IR[31:25] = imm[11:5]; IR[11:7] = imm[4:0].
  - LUI, AUIPC: U format. IR[31:12] = imm[31:12].
  - JAL: J format. IR[31] = imm[20]; IR[30:21] = imm[10:1]; IR[20] = imm[11]; IR[19:12] = imm[19:12].
  - Branch: B format. IR[31] = imm[12]; IR[30:25] = imm[10:5]; IR[11:8] = imm[4:1]; IR[7] = imm[11].
- Packed immediate bits are ORed into in_base. Immediate bits not listed for the format are discarded.
- LI expansion, with rd = in_base[11:7], lo = in_imm[11:0] and hi = (in_imm + 32'h800)[31:12] (32-bit wrap):
  - -2048 ≤ in_imm ≤ 2047: emit a single `ADDI rd, x0, lo`.
  - else if lo == 0: emit a single `LUI rd, hi`.
  - else: emit `LUI rd, hi`, then `ADDI rd, rd, lo`.
  - out_err is always 0 for LI.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready. On accept, the output register loads the first (or only) word. A two-word LI also captures the ADDI word in a pending register and moves to SECOND.
  - SECOND: in_ready = 0. When the LUI word is consumed (out_valid && out_ready), the output register loads the pending ADDI word with out_valid=1, and the FSM returns to IDLE.
- Simultaneous consume and accept in IDLE: the new word replaces the old one in the same edge, with no bubble.
- out_valid=1 with out_ready=0: out_ir and out_err hold stable.

## Timing
- Latency: accept at edge N gives out_valid=1 with the word after edge N.
- LI pair: the ADDI word appears on the edge after the LUI word is consumed.
- Throughput: one word per cycle under continuous out_ready=1. A two-word LI therefore occupies two cycles.
- Reset values: out_valid=0, out_ir=0, out_err=0, FSM=IDLE, pending register=0. in_ready=1 after reset.
- Reset asserted in SECOND drops the pending ADDI word.

## Configuration
- Macro: RV32_IMM_RANGE_CHECK_EN.
- Defined: out_err=1 when the immediate does not fit its format:
  - I/S: in_imm is not the sign-extension of in_imm[11:0].
  - B: not the sign-extension of [12:0], or imm[0]=1.
  - J: not the sign-extension of [20:0], or imm[0]=1.
  - U: imm[11:0]≠0.
  - The word is still encoded with truncation as normal.
- Undefined: out_err is tied to 0 and no check logic is built.

## Structure
- Opcode macros (OPCODE_Arith_I, OPCODE_Store, OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_Branch) come from the shared defines.v.
- Add to defines.v: the ADDI funct3 constant and the FSM state encodings (IDLE=1'b0, SECOND=1'b1).
- Sub-module rv32_imm_pack: combinational (base, imm) → (ir, err) format insertion. It is instantiated twice: once for the first word, once for the pending ADDI word.

## Test plan
- Single I-format word: in_base=32'h00000093 (ADDI x1,x0), in_imm=32'hFFFFFFFF → out_ir=32'hFFF00093 one cycle later, out_err=0.
- Branch: in_base=32'h00208063 (BEQ x1,x2), in_imm=8 → 32'h00208463. With in_imm=7 and RV32_IMM_RANGE_CHECK_EN defined → 32'h00208363, out_err=1.
- Two-word LI: in_li=1, rd=5, in_imm=32'h12345678 → 32'h123452B7 then 32'h67828293; in_ready=0 between the two words.
- LI rounding: in_imm=32'h00000FFF, rd=5 → 32'h000012B7 then 32'hFFF28293. LI in_imm=32'h00010000 → single word 32'h000102B7.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 → out_ir stable and in_ready=0. Then back-to-back accepts with out_ready=1 → one word per cycle, no drops or duplicates.
- Reset mid-LI: assert rst while in SECOND → out_valid=0 immediately (asynchronous). After release, IDLE with in_ready=1 and no ADDI word emitted.
